// File: rtl/rstatus_reader_pkg.sv
// Shared constants and FSM state type for the $r30 (rstatus) read path.
package rstatus_reader_pkg;

  localparam logic [4:0]  STATUS_REG = 5'd30;
  localparam int unsigned PIPE_DEPTH = 3;

  localparam logic [31:0] EXC_ADD  = 32'd1;
  localparam logic [31:0] EXC_ADDI = 32'd2;
  localparam logic [31:0] EXC_SUB  = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } bex_state_e;

  function automatic logic is_exc_code(input logic [31:0] v);
    return (v == EXC_ADD) || (v == EXC_ADDI) || (v == EXC_SUB);
  endfunction

endpackage

// File: rtl/rstatus_reader_pend_tracker.sv
// Tracks in-flight $r30 producers (bit 0 = X, top bit = W) and provides
// the busy flag plus the same-cycle writeback bypass of rstatus.
module status_pend_tracker #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        advance_i,
  input  logic        push_i,
  input  logic        commit_i,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] rstatus_i,
  output logic        busy_o,
  output logic [31:0] cur_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [DEPTH-1:0] w_commit_mask;

  always_comb begin
    pend_d = pend_q;
    if (advance_i) begin
      pend_d = {pend_q[DEPTH-2:0], push_i};
    end
  end

  // A W-slot producer writing $r30 this cycle is already final via the bypass.
  always_comb begin
    w_commit_mask            = '0;
    w_commit_mask[DEPTH-1]   = commit_i;
  end

  assign busy_o = |(pend_q & ~w_commit_mask);
  assign cur_o  = commit_i ? wb_data_i : rstatus_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/rstatus_reader.sv
// Decode-side bex resolution against the $r30 shadow register.
// Optional RSTATUS_EXC_COUNT_EN adds exc_count (saturating count of exception-code commits).
module rstatus_reader
  import rstatus_reader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        pipe_advance,
  input  logic        flush,
  input  logic        issue_valid,
  input  logic        issue_writes_stat,
  input  logic        bex_valid,
  input  logic [26:0] bex_target,
  output logic        stall,
  output logic        bex_taken,
  output logic [11:0] bex_pc,
`ifdef RSTATUS_EXC_COUNT_EN
  output logic [15:0] exc_count,
`endif
  output logic [31:0] rstatus_q
);

  bex_state_e  state_q;
  logic        bex_taken_q;
  logic [11:0] bex_pc_q;
  logic        commit;
  logic        push;
  logic        busy;
  logic [31:0] cur;
  logic        unused_target_hi;

  assign commit           = wb_we && (wb_reg == STATUS_REG);
  assign unused_target_hi = ^bex_target[26:12];

  // A bex already waiting keeps decode frozen even if bex_valid is deasserted.
  assign stall = busy && !flush && (bex_valid || (state_q == ST_WAIT));
  assign push  = issue_valid && issue_writes_stat && !stall && !flush;

  status_pend_tracker #(
    .DEPTH(PIPE_DEPTH)
  ) u_pend (
    .clk_i     (clock),
    .rst_i     (reset),
    .advance_i (pipe_advance),
    .push_i    (push),
    .commit_i  (commit),
    .wb_data_i (wb_data),
    .rstatus_i (rstatus_q),
    .busy_o    (busy),
    .cur_o     (cur)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rstatus_q <= '0;
    end else if (commit) begin
      rstatus_q <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bex_taken_q <= 1'b0;
      bex_pc_q    <= '0;
    end else begin
      bex_taken_q <= 1'b0;
      // RESOLVE always drops back so the pulse is single even under a freeze.
      if (state_q == ST_RESOLVE) begin
        state_q <= ST_IDLE;
      end
      if (pipe_advance) begin
        unique case (state_q)
          ST_IDLE, ST_RESOLVE: begin
            if (bex_valid && !flush) begin
              if (busy) begin
                state_q <= ST_WAIT;
              end else begin
                state_q     <= ST_RESOLVE;
                bex_taken_q <= (cur != '0);
                bex_pc_q    <= bex_target[11:0];
              end
            end
          end
          ST_WAIT: begin
            if (flush) begin
              state_q <= ST_IDLE;
            end else if (!busy) begin
              state_q     <= ST_RESOLVE;
              bex_taken_q <= (cur != '0);
              bex_pc_q    <= bex_target[11:0];
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bex_taken = bex_taken_q;
  assign bex_pc    = bex_pc_q;

`ifdef RSTATUS_EXC_COUNT_EN
  logic [15:0] exc_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      exc_count_q <= '0;
    end else if (commit && is_exc_code(wb_data) && (exc_count_q != '1)) begin
      exc_count_q <= exc_count_q + 16'd1;
    end
  end

  assign exc_count = exc_count_q;
`endif

endmodule

// File: tb/tb_rstatus_reader.sv
// Scoreboard bench for rstatus_reader: driver pushes expected bex redirects,
// monitor pops them on every bex_taken pulse.
module tb_rstatus_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        pipe_advance;
  logic        flush;
  logic        issue_valid;
  logic        issue_writes_stat;
  logic        bex_valid;
  logic [26:0] bex_target;
  logic        stall;
  logic        bex_taken;
  logic [11:0] bex_pc;
  logic [31:0] rstatus_q;
`ifdef RSTATUS_EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  rstatus_reader dut (
    .clock             (clock),
    .reset             (reset),
    .wb_we             (wb_we),
    .wb_reg            (wb_reg),
    .wb_data           (wb_data),
    .pipe_advance      (pipe_advance),
    .flush             (flush),
    .issue_valid       (issue_valid),
    .issue_writes_stat (issue_writes_stat),
    .bex_valid         (bex_valid),
    .bex_target        (bex_target),
    .stall             (stall),
    .bex_taken         (bex_taken),
    .bex_pc            (bex_pc),
`ifdef RSTATUS_EXC_COUNT_EN
    .exc_count         (exc_count),
`endif
    .rstatus_q         (rstatus_q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] pc;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_rstat  = '0;
  int          m_exc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every redirect pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bex_taken) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bex_taken", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bex_pc", {20'd0, bex_pc}, {20'd0, e.pc});
        check("bex_taken_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle_inputs();
    wb_we = 0; wb_reg = '0; wb_data = '0; pipe_advance = 1; flush = 0;
    issue_valid = 0; issue_writes_stat = 0; bex_valid = 0; bex_target = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_commit(input logic [31:0] v);
    m_rstat = v;
    if (v >= 32'd1 && v <= 32'd3 && m_exc < 65535) m_exc++;
  endtask

  task automatic quiet_cycle();
    step(); idle_inputs();
    @(negedge clock);
    check("stall_quiet", {31'd0, stall}, 32'd0);
    check("rstatus_q", rstatus_q, m_rstat);
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    step(); idle_inputs();
    wb_we = 1; wb_reg = r; wb_data = v;
    issue_valid = 1'($urandom_range(0, 1));   // non-status instruction, must not be tracked
    @(negedge clock);
    check("stall_write", {31'd0, stall}, 32'd0);
    if (r == 5'd30) model_commit(v);
  endtask

  task automatic do_reset();
    step(); idle_inputs();
    reset = 1;
    @(negedge clock);
    step(); reset = 0;
    m_rstat = '0; m_exc = 0;
    exp_q.delete();
    @(negedge clock);
    check("reset_bex_taken", {31'd0, bex_taken}, 32'd0);
    check("reset_bex_pc", {20'd0, bex_pc}, 32'd0);
    check("reset_rstatus_q", rstatus_q, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
  endtask

  // A producer leaves decode in cycle 0 and then occupies X, M, W on successive
  // advancing cycles; the bex enters decode later and resolves on the first
  // advancing cycle in which no producer is still unresolved.
  task automatic run_bex(input bit has_prod, input bit prod_commit, input logic [31:0] prod_data,
                         input int gap, input logic [26:0] tgt, input int flush_wait,
                         input bit freeze_en);
    int i, stage, wait_cnt, bex_start;
    bit done, issued, adv, w_commit, busy, exp_stall;
    logic [31:0] cur;
    i = 0; stage = 0; wait_cnt = 0; done = 0; issued = 0;
    bex_start = has_prod ? 1 + gap : 0;
    while (!(done && (!has_prod || stage >= 4))) begin
      if (i >= 80) begin
        check("bex_resolve_timeout", 32'd0, 32'd1);
        break;
      end
      step(); idle_inputs();
      adv = (i == 0 || !freeze_en) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pipe_advance = adv;
      if (has_prod && i == 0) begin
        issue_valid = 1; issue_writes_stat = 1;
      end
      w_commit = has_prod && issued && stage == 3 && adv && prod_commit;
      busy = has_prod && issued && (stage == 1 || stage == 2 || (stage == 3 && !w_commit));
      if (w_commit) begin
        wb_we = 1; wb_reg = 5'd30; wb_data = prod_data;
      end
      if (!done && i >= bex_start) begin
        bex_valid = 1; bex_target = tgt;
        if (flush_wait >= 0 && wait_cnt == flush_wait && adv) flush = 1;
      end
      @(negedge clock);
      check("rstatus_q", rstatus_q, m_rstat);
      if (!done && i >= bex_start) begin
        exp_stall = busy && !flush;
        check("stall_bex", {31'd0, stall}, {31'd0, exp_stall});
        if (flush) begin
          done = 1;
        end else if (!busy && adv) begin
          cur = w_commit ? prod_data : m_rstat;
          if (cur != 0) exp_q.push_back('{tgt[11:0], cyc + 1});
          done = 1;
        end else if (busy) begin
          wait_cnt++;
        end
      end else begin
        check("stall_quiet", {31'd0, stall}, 32'd0);
      end
      if (w_commit) model_commit(prod_data);
      if (has_prod && i == 0) begin
        issued = 1; stage = 1;
      end else if (issued && adv) begin
        stage++;
      end
      i++;
    end
  endtask

  // A second bex arriving while the FSM sits in RESOLVE is evaluated at once.
  task automatic back_to_back(input logic [26:0] tgt);
    step(); idle_inputs();
    bex_valid = 1; bex_target = tgt;
    @(negedge clock);
    check("stall_b2b", {31'd0, stall}, 32'd0);
    if (m_rstat != 0) exp_q.push_back('{tgt[11:0], cyc + 1});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0, 1:    return 32'd0;
      2:       return 32'd1;
      3:       return 32'd2;
      4:       return 32'd3;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    do_reset();

    // No producers, rstatus 0: no stall, no redirect.
    run_bex(0, 0, 0, 0, 27'd100, -1, 0);
    quiet_cycle(); quiet_cycle();

    // rstatus=3 committed earlier: redirect to 0x040.
    write_reg(5'd30, 32'd3);
    quiet_cycle();
    run_bex(0, 0, 0, 0, 27'h40, -1, 0);
    quiet_cycle(); quiet_cycle();

    // setx in flight, bex right behind it, W commit resolves through bypass.
    write_reg(5'd30, 32'd0);
    run_bex(1, 1, 32'd5, 0, 27'h7ff_f123, -1, 0);
    quiet_cycle(); quiet_cycle();

    // add without overflow: waits for W retirement, rstatus stays 0.
    write_reg(5'd30, 32'd0);
    run_bex(1, 0, 0, 0, 27'h55, -1, 0);
    quiet_cycle(); quiet_cycle();

    // Flush while waiting kills the bex.
    write_reg(5'd30, 32'd9);
    run_bex(1, 0, 0, 0, 27'h66, 1, 0);
    quiet_cycle(); quiet_cycle();

    // Flush together with an unblocked bex: flush wins.
    run_bex(0, 0, 0, 0, 27'h77, 0, 0);
    quiet_cycle(); quiet_cycle();

    // Back-to-back bex with the second landing in RESOLVE.
    run_bex(0, 0, 0, 0, 27'h123, -1, 0);
    back_to_back(27'h456);
    quiet_cycle(); quiet_cycle();

    // Reset in the cycle a taken bex would resolve: no pulse afterwards.
    write_reg(5'd30, 32'd7);
    step(); idle_inputs();
    bex_valid = 1; bex_target = 27'h321; reset = 1;
    @(negedge clock);
    step(); idle_inputs(); reset = 0;
    m_rstat = '0; m_exc = 0;
    @(negedge clock);
    check("reset_resolve_rstatus", rstatus_q, 32'd0);
    quiet_cycle(); quiet_cycle();

    // Reset while waiting: pend cleared, the re-presented bex is not blocked.
    write_reg(5'd30, 32'd4);
    step(); idle_inputs(); issue_valid = 1; issue_writes_stat = 1;
    @(negedge clock);
    step(); idle_inputs(); bex_valid = 1; bex_target = 27'h11;
    @(negedge clock);
    check("stall_wait_before_reset", {31'd0, stall}, 32'd1);
    step(); idle_inputs(); reset = 1;
    @(negedge clock);
    step(); idle_inputs(); reset = 0;
    m_rstat = '0; m_exc = 0;
    bex_valid = 1; bex_target = 27'h11;
    @(negedge clock);
    check("stall_after_reset", {31'd0, stall}, 32'd0);
    quiet_cycle(); quiet_cycle();

    // Exception-code commits: 1, 2, 3 counted, 7 not.
    write_reg(5'd30, 32'd1);
    write_reg(5'd30, 32'd2);
    write_reg(5'd30, 32'd3);
    write_reg(5'd30, 32'd7);
    write_reg(5'd12, 32'd1);
    quiet_cycle();
`ifdef RSTATUS_EXC_COUNT_EN
    check("exc_count_directed", {16'd0, exc_count}, 32'd3);
`endif

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) write_reg(5'($urandom_range(0, 29)), $urandom);
      write_reg(5'd30, pick_val());
      run_bex(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), pick_val(),
              int'($urandom_range(0, 4)), 27'($urandom),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1,
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        run_bex(0, 0, 0, 0, 27'($urandom), -1, 0);
        back_to_back(27'($urandom));
      end
      quiet_cycle();
      quiet_cycle();
    end

    quiet_cycle(); quiet_cycle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef RSTATUS_EXC_COUNT_EN
    check("exc_count_final", {16'd0, exc_count}, m_exc);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
